load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage data-side bus master of the RV32I 5-stage pipeline.
- Takes the memory-stage access (address, store data, funct3, read/write) and runs a req/gnt/rvalid transaction on the data bus.
- Generates byte enables and store-lane replication; aligns and sign/zero-extends load data.
- Stalls the whole pipeline while a transaction is outstanding; flags misaligned or unsupported accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: cycles allowed from entering REQ until rvalid. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- Funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ALU_ResultM  in  32  byte address
- WriteDataM  in  32  store data (low lanes)
- ReadDataM  out  32  aligned, extended load result
- StallM  out  1  freeze all pipeline registers
- AddrFaultM  out  1  misaligned or unsupported funct3; access suppressed
- BusErrM  out  1  transaction timed out
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/ack; valid no earlier than 1 cycle after gnt
- bus_rdata  in  32  read data

Behaviour:
- Reset (asynchronous, rst=0):
  - State returns to IDLE.
  - All registered outputs go to 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, ReadDataM, BusErrM, timeout counter.
  - StallM=0 and AddrFaultM=0.
- Access valid = MemReadM | MemWriteM. If both are set, treat the access as a write.
- Fault check (combinational, IDLE only):
  - H with addr[0]=1 is a fault.
  - W with addr[1:0]≠0 is a fault.
  - funct3 ∈ {011, 110, 111} is a fault, as are stores with funct3[2]=1.
  - On a fault: AddrFaultM=1, no bus request, StallM=0, store suppressed.
- States: IDLE, REQ, WAIT, DONE.
  - IDLE: on a valid, non-faulting access, register bus_addr/bus_we/bus_be/bus_wdata plus addr[1:0] and funct3, set bus_req=1, clear the counter, clear BusErrM, go to REQ.
  - REQ: hold bus_req and all bus fields stable until bus_gnt. On gnt, drop bus_req and go to WAIT.
  - WAIT: on bus_rvalid, latch the aligned result into ReadDataM (loads only; stores leave ReadDataM unchanged) and go to DONE.
  - DONE: always returns to IDLE next cycle. No new request may be issued from DONE, because the inputs still belong to the completed instruction.
- Timeout:
  - The counter increments each cycle in REQ and WAIT.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without rvalid: drop bus_req, set BusErrM=1, set ReadDataM=0, go to DONE.
  - BusErrM holds until the next issued access.
- StallM = valid & ~fault & (state ≠ DONE).
  - Minimum load/store occupancy is 4 cycles: IDLE, REQ (gnt same cycle), WAIT (rvalid), DONE.
  - StallM is high for the first 3 of those cycles and low in DONE, so the M/W register captures ReadDataM at the end of DONE.
- Store lanes:
  - SB: wdata={4{WriteDataM[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{WriteDataM[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - SW: wdata=WriteDataM, be=4'b1111.
- Loads:
  - bus_be follows the same size/offset rule as stores.
  - Extract the byte/half from bus_rdata using the registered addr[1:0].
  - B/H are sign-extended; BU/HU are zero-extended.
- bus_rvalid is ignored in IDLE, REQ and DONE (e.g. a stale response after reset).
- bus_gnt is ignored outside REQ.
- Reset mid-transaction: bus_req drops immediately (asynchronously) and no response is accepted afterwards.

Decomposition:
- Shared package: funct3 encodings (LB/LH/LW/LBU/LHU, SB/SH/SW) and the state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3).
- One sub-module, lsu_align (combinational):
  - store lane replication and byte-enable generation;
  - load extraction and extension.
  - Ports: funct3, addr[1:0], wdata_in → be, wdata_out; rdata_in → rdata_out.

Test Plan:
- LW at 0x100, gnt in REQ, rvalid next cycle with 0xDEADBEEF → bus_addr=0x100, be=1111, StallM high 3 cycles then low, ReadDataM=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80000000 → ReadDataM=0xFFFFFF80; same access as LBU → 0x00000080; LHU at 0x102, rdata=0xBEEF0000 → 0x0000BEEF.
- SH at 0x202, WriteDataM=0x1234ABCD → bus_we=1, bus_addr=0x200, be=1100, wdata=0xABCDABCD; ReadDataM unchanged.
- LW at 0x101 → AddrFaultM=1, bus_req stays 0, StallM=0; funct3=011 load → AddrFaultM=1.
- gnt withheld 3 cycles → bus_req, addr, be, wdata stable throughout; StallM extended by 3 cycles; back-to-back SW issues a new request only from IDLE, after DONE.
- TIMEOUT=4 with no rvalid → BusErrM=1 and ReadDataM=0 in DONE, bus_req low. rst pulled low in WAIT → IDLE with outputs 0; an rvalid arriving afterwards → ignored, ReadDataM stays 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the memory-stage load/store unit:
//   - funct3 access encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - transaction state encoding (IDLE/REQ/WAIT/DONE)
//   - access_fault(): size/alignment/encoding legality check
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Returns 1 when the access cannot be issued: misaligned half/word,
    // reserved funct3, or an unsigned-size encoding used by a store.
    function automatic logic access_fault(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic       is_store);
        logic f;
        f = 1'b0;
        case (f3)
            F3_LB:   f = 1'b0;
            F3_LH:   f = off[0];
            F3_LW:   f = (off != 2'b00);
            F3_LBU:  f = is_store;
            F3_LHU:  f = is_store | off[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational data-path helper for the load/store unit.
//   funct3_i  [2:0]  access size/sign
//   addr_i    [1:0]  byte offset inside the word
//   wdata_i   [31:0] store data (low lanes significant)
//   rdata_i   [31:0] raw bus read word
//   be_o      [3:0]  byte enables for the access
//   wdata_o   [31:0] store data replicated across all lanes
//   rdata_o   [31:0] extracted and sign/zero-extended load value
// -----------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte enables and lane replication depend only on the size bits, so the
    // same rule serves loads and stores.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
    end

    // Extend the extracted value according to the load type.
    always_comb begin
        rdata_o = 32'h0000_0000;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{byte_s[7]}}, byte_s};
            F3_LH:   rdata_o = {{16{half_s[15]}}, half_s};
            F3_LW:   rdata_o = rdata_i;
            F3_LBU:  rdata_o = {24'h00_0000, byte_s};
            F3_LHU:  rdata_o = {16'h0000, half_s};
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage data bus master. Issues one req/gnt/rvalid transaction per
// load or store, stalls the pipeline while it is outstanding, and reports
// illegal accesses (AddrFaultM) and bus timeouts (BusErrM).
//   clk, rst (async, active-low)
//   MemReadM, MemWriteM, Funct3M[2:0], ALU_ResultM[31:0], WriteDataM[31:0]
//       memory-stage access; a simultaneous read+write is treated as a write
//   ReadDataM[31:0] aligned load result (registered)
//   StallM          freeze all pipeline registers
//   AddrFaultM      access suppressed (misaligned / unsupported funct3)
//   BusErrM         last transaction timed out (registered)
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   registered request fields
//   bus_gnt, bus_rvalid, bus_rdata              bus responses
// Parameter TIMEOUT: cycles allowed from entering REQ until rvalid; 0 = off.
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        AddrFaultM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit                TO_EN    = (TIMEOUT != 0);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_req_q;
    logic             bus_we_q;
    logic [31:0]      bus_addr_q;
    logic [3:0]       bus_be_q;
    logic [31:0]      bus_wdata_q;
    logic [31:0]      read_data_q;
    logic             bus_err_q;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;

    logic             access_valid_s;
    logic             fault_s;
    logic             timeout_s;
    logic [2:0]       align_f3_s;
    logic [1:0]       align_off_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic [31:0]      rdata_s;

    // Access qualification. In IDLE the aligner sees the live request (to
    // build be/wdata); afterwards it sees the registered size/offset so the
    // returned word is extracted for the instruction that issued it.
    always_comb begin
        access_valid_s = MemReadM | MemWriteM;
        if (state_q == LSU_IDLE) begin
            fault_s     = access_valid_s & access_fault(Funct3M, ALU_ResultM[1:0], MemWriteM);
            align_f3_s  = Funct3M;
            align_off_s = ALU_ResultM[1:0];
        end else begin
            fault_s     = 1'b0;
            align_f3_s  = f3_q;
            align_off_s = off_q;
        end
        timeout_s = TO_EN && (cnt_q == CNT_LAST);
    end

    lsu_align u_align (
        .funct3_i (align_f3_s),
        .addr_i   (align_off_s),
        .wdata_i  (WriteDataM),
        .rdata_i  (bus_rdata),
        .be_o     (be_s),
        .wdata_o  (wdata_s),
        .rdata_o  (rdata_s)
    );

    // Transaction FSM with its registered bus and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LSU_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            read_data_q <= 32'h0000_0000;
            bus_err_q   <= 1'b0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (access_valid_s && !fault_s) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= MemWriteM;
                        bus_addr_q  <= {ALU_ResultM[31:2], 2'b00};
                        bus_be_q    <= be_s;
                        bus_wdata_q <= wdata_s;
                        off_q       <= ALU_ResultM[1:0];
                        f3_q        <= Funct3M;
                        cnt_q       <= '0;
                        bus_err_q   <= 1'b0;
                        state_q     <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Timeout wins over a same-cycle grant: the request is
                    // withdrawn and the pipeline released with an error.
                    if (timeout_s) begin
                        bus_req_q   <= 1'b0;
                        bus_err_q   <= 1'b1;
                        read_data_q <= 32'h0000_0000;
                        state_q     <= LSU_DONE;
                    end else if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus_rvalid) begin
                        if (!bus_we_q) begin
                            read_data_q <= rdata_s;
                        end
                        state_q <= LSU_DONE;
                    end else if (timeout_s) begin
                        bus_req_q   <= 1'b0;
                        bus_err_q   <= 1'b1;
                        read_data_q <= 32'h0000_0000;
                        state_q     <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    // Inputs still belong to the finished instruction, so
                    // never issue from here.
                    state_q <= LSU_IDLE;
                end
                default: begin
                    state_q   <= LSU_IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign ReadDataM  = read_data_q;
    assign BusErrM    = bus_err_q;

    // Gated by rst so both flags are quiet while reset is held.
    assign AddrFaultM = rst & fault_s;
    assign StallM     = rst & access_valid_s & ~fault_s & (state_q != LSU_DONE);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemReadM, MemWriteM, to_read, to_write;
    logic [2:0]  Funct3M;
    logic [31:0] ALU_ResultM, WriteDataM;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    logic [31:0] ReadDataM, bus_addr, bus_wdata;
    logic        StallM, AddrFaultM, BusErrM, bus_req, bus_we;
    logic [3:0]  bus_be;

    logic [31:0] to_rdm, to_addr, to_wdata;
    logic        to_stall, to_fault, to_err, to_req, to_we;
    logic [3:0]  to_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit u_dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .AddrFaultM(AddrFaultM),
        .BusErrM(BusErrM), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    load_store_unit #(.TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst), .MemReadM(to_read), .MemWriteM(to_write),
        .Funct3M(Funct3M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .ReadDataM(to_rdm), .StallM(to_stall), .AddrFaultM(to_fault),
        .BusErrM(to_err), .bus_req(to_req), .bus_we(to_we), .bus_addr(to_addr),
        .bus_be(to_be), .bus_wdata(to_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        MemReadM = 1'b0; MemWriteM = 1'b0; to_read = 1'b0; to_write = 1'b0;
        Funct3M = 3'b000; ALU_ResultM = 32'h0; WriteDataM = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    endtask

    // Runs one access on u_dut acting as a bus slave; gnt after gnt_delay
    // REQ cycles, rvalid one cycle after gnt. Returns what was observed.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gnt_delay, input bit give_rvalid,
                          output logic [31:0] rd, output int stalls, output logic [3:0] be,
                          output logic [31:0] baddr, output logic [31:0] bwdata,
                          output logic bwe, output bit stable, output logic berr);
        int req_n;
        bit granted;
        bit seen;
        req_n = 0; granted = 1'b0; seen = 1'b0; stalls = 0; stable = 1'b1;
        be = 4'h0; baddr = 32'h0; bwdata = 32'h0; bwe = 1'b0;
        cyc();
        MemReadM = ~we; MemWriteM = we; Funct3M = f3; ALU_ResultM = addr;
        WriteDataM = wdata; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        settle();
        for (int n = 0; n < 60; n++) begin
            if (!StallM) break;
            stalls++;
            bus_rvalid = 1'b0;
            bus_gnt = 1'b0;
            if (bus_req) begin
                if (!seen) begin
                    be = bus_be; baddr = bus_addr; bwdata = bus_wdata; bwe = bus_we; seen = 1'b1;
                end else if (bus_be !== be || bus_addr !== baddr || bus_wdata !== bwdata || bus_we !== bwe) begin
                    stable = 1'b0;
                end
                req_n++;
                bus_gnt = (req_n > gnt_delay);
            end else if (granted && give_rvalid) begin
                bus_rvalid = 1'b1;
                bus_rdata = rdata;
            end
            granted = bus_req && bus_gnt;
            cyc();
            settle();
        end
        rd = ReadDataM;
        berr = BusErrM;
        cyc();
        MemReadM = 1'b0; MemWriteM = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        settle();
    endtask

    logic [31:0] rd, baddr, bwdata;
    int          stalls;
    logic [3:0]  be;
    logic        bwe, berr;
    bit          stable;

    task automatic test_reset();
        idle_inputs();
        MemReadM = 1'b1; Funct3M = 3'b011;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== 70'h0) begin
            errors++; $display("FAIL reset_bus got req=%0b we=%0b addr=%h be=%h wdata=%h exp all 0", bus_req, bus_we, bus_addr, bus_be, bus_wdata);
        end
        checks++;
        if ({ReadDataM, BusErrM, StallM, AddrFaultM} !== 35'h0) begin
            errors++; $display("FAIL reset_status got rd=%h err=%0b stall=%0b fault=%0b exp all 0", ReadDataM, BusErrM, StallM, AddrFaultM);
        end
        idle_inputs();
        #1 rst = 1'b1;
    endtask

    task automatic test_lw();
        cyc();
        MemReadM = 1'b1; Funct3M = F3_LW; ALU_ResultM = 32'h100; bus_gnt = 1'b1;
        settle();
        checks++;
        if ({StallM, bus_req} !== 2'b10) begin
            errors++; $display("FAIL lw_idle got stall=%0b req=%0b exp stall=1 req=0", StallM, bus_req);
        end
        cyc(); settle();
        checks++;
        if ({StallM, bus_req, bus_we, bus_addr, bus_be} !== {3'b110, 32'h100, 4'b1111}) begin
            errors++; $display("FAIL lw_req got stall=%0b req=%0b we=%0b addr=%h be=%b exp 1 1 0 00000100 1111", StallM, bus_req, bus_we, bus_addr, bus_be);
        end
        cyc();
        bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
        settle();
        checks++;
        if ({StallM, bus_req} !== 2'b10) begin
            errors++; $display("FAIL lw_wait got stall=%0b req=%0b exp stall=1 req=0", StallM, bus_req);
        end
        cyc();
        bus_rvalid = 1'b0;
        settle();
        checks++;
        if ({StallM, ReadDataM} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL lw_done got stall=%0b rd=%h exp stall=0 rd=deadbeef", StallM, ReadDataM);
        end
        cyc();
        idle_inputs();
        settle();
    endtask

    task automatic test_load_ext();
        access(1'b0, F3_LB, 32'h103, 32'h0, 32'h8000_0000, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if ({rd, be, baddr} !== {32'hFFFF_FF80, 4'b1000, 32'h100}) begin
            errors++; $display("FAIL lb_sext got rd=%h be=%b addr=%h exp ffffff80 1000 00000100", rd, be, baddr);
        end
        checks++;
        if (stalls !== 3) begin
            errors++; $display("FAIL lb_stall_cycles got %0d exp 3", stalls);
        end
        access(1'b0, F3_LBU, 32'h103, 32'h0, 32'h8000_0000, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if (rd !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu_zext got %h exp 00000080", rd);
        end
        access(1'b0, F3_LHU, 32'h102, 32'h0, 32'hBEEF_0000, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if ({rd, be} !== {32'h0000_BEEF, 4'b1100}) begin
            errors++; $display("FAIL lhu_zext got rd=%h be=%b exp 0000beef 1100", rd, be);
        end
        access(1'b0, F3_LH, 32'h102, 32'h0, 32'h8001_0000, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if (rd !== 32'hFFFF_8001) begin
            errors++; $display("FAIL lh_sext got %h exp ffff8001", rd);
        end
        access(1'b0, F3_LH, 32'h000, 32'h0, 32'h1234_5678, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if ({rd, be} !== {32'h0000_5678, 4'b0011}) begin
            errors++; $display("FAIL lh_low got rd=%h be=%b exp 00005678 0011", rd, be);
        end
        access(1'b0, F3_LB, 32'h101, 32'h0, 32'h0000_7F00, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if ({rd, be} !== {32'h0000_007F, 4'b0010}) begin
            errors++; $display("FAIL lb_pos got rd=%h be=%b exp 0000007f 0010", rd, be);
        end
    endtask

    task automatic test_store();
        access(1'b1, F3_SH, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if ({bwe, baddr, be, bwdata} !== {1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD}) begin
            errors++; $display("FAIL sh_bus got we=%0b addr=%h be=%b wdata=%h exp 1 00000200 1100 abcdabcd", bwe, baddr, be, bwdata);
        end
        checks++;
        if (rd !== 32'h0000_007F) begin
            errors++; $display("FAIL sh_keeps_rd got %h exp 0000007f", rd);
        end
        access(1'b1, F3_SB, 32'h201, 32'h0000_00EF, 32'h0, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if ({be, bwdata} !== {4'b0010, 32'hEFEF_EFEF}) begin
            errors++; $display("FAIL sb_lanes got be=%b wdata=%h exp 0010 efefefef", be, bwdata);
        end
    endtask

    task automatic test_fault();
        cyc();
        MemReadM = 1'b1; Funct3M = F3_LW; ALU_ResultM = 32'h101; bus_gnt = 1'b1;
        settle();
        checks++;
        if ({AddrFaultM, StallM} !== 2'b10) begin
            errors++; $display("FAIL lw_misalign got fault=%0b stall=%0b exp 1 0", AddrFaultM, StallM);
        end
        cyc(); settle();
        checks++;
        if ({bus_req, AddrFaultM} !== 2'b01) begin
            errors++; $display("FAIL lw_misalign_noreq got req=%0b fault=%0b exp 0 1", bus_req, AddrFaultM);
        end
        Funct3M = 3'b011; ALU_ResultM = 32'h100;
        #1;
        checks++;
        if ({AddrFaultM, StallM} !== 2'b10) begin
            errors++; $display("FAIL f3_011 got fault=%0b stall=%0b exp 1 0", AddrFaultM, StallM);
        end
        MemReadM = 1'b0; MemWriteM = 1'b1; Funct3M = 3'b100;
        #1;
        checks++;
        if ({AddrFaultM, StallM} !== 2'b10) begin
            errors++; $display("FAIL store_f3_100 got fault=%0b stall=%0b exp 1 0", AddrFaultM, StallM);
        end
        Funct3M = F3_SH; ALU_ResultM = 32'h201;
        #1;
        checks++;
        if (AddrFaultM !== 1'b1) begin
            errors++; $display("FAIL sh_odd got fault=%0b exp 1", AddrFaultM);
        end
        MemWriteM = 1'b0; MemReadM = 1'b1; Funct3M = F3_LH; ALU_ResultM = 32'h102;
        #1;
        checks++;
        if ({AddrFaultM, StallM} !== 2'b01) begin
            errors++; $display("FAIL lh_aligned got fault=%0b stall=%0b exp 0 1", AddrFaultM, StallM);
        end
        idle_inputs();
        cyc(); settle();
        checks++;
        if (bus_req !== 1'b0) begin
            errors++; $display("FAIL fault_no_issue got req=%0b exp 0", bus_req);
        end
    endtask

    task automatic test_gnt_stall();
        access(1'b1, F3_SW, 32'h300, 32'hCAFE_F00D, 32'h0, 3, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if (stalls !== 6) begin
            errors++; $display("FAIL gnt_delay_stalls got %0d exp 6", stalls);
        end
        checks++;
        if ({stable, bwe, baddr, be, bwdata} !== {2'b11, 32'h300, 4'b1111, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL gnt_delay_fields got stable=%0b we=%0b addr=%h be=%b wdata=%h exp 1 1 00000300 1111 cafef00d", stable, bwe, baddr, be, bwdata);
        end
    endtask

    task automatic test_back_to_back();
        cyc();
        MemWriteM = 1'b1; Funct3M = F3_SW; ALU_ResultM = 32'h400; WriteDataM = 32'h1111_1111; bus_gnt = 1'b1;
        settle();
        cyc(); settle();
        checks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h400}) begin
            errors++; $display("FAIL b2b_first_req got req=%0b addr=%h exp 1 00000400", bus_req, bus_addr);
        end
        cyc(); bus_rvalid = 1'b1; settle();
        cyc(); bus_rvalid = 1'b0; settle();
        checks++;
        if ({bus_req, StallM} !== 2'b00) begin
            errors++; $display("FAIL b2b_done got req=%0b stall=%0b exp 0 0", bus_req, StallM);
        end
        cyc();
        ALU_ResultM = 32'h404; WriteDataM = 32'h2222_2222;
        settle();
        checks++;
        if ({bus_req, StallM} !== 2'b01) begin
            errors++; $display("FAIL b2b_idle got req=%0b stall=%0b exp 0 1", bus_req, StallM);
        end
        cyc(); settle();
        checks++;
        if ({bus_req, bus_addr, bus_wdata} !== {1'b1, 32'h404, 32'h2222_2222}) begin
            errors++; $display("FAIL b2b_second_req got req=%0b addr=%h wdata=%h exp 1 00000404 22222222", bus_req, bus_addr, bus_wdata);
        end
        cyc(); bus_rvalid = 1'b1; settle();
        cyc(); bus_rvalid = 1'b0; settle();
        cyc(); idle_inputs(); settle();
    endtask

    task automatic test_timeout();
        access(1'b0, F3_LW, 32'h500, 32'h0, 32'h0, 1000, 1'b0, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if ({stalls, berr, rd} !== {32'd17, 1'b1, 32'h0}) begin
            errors++; $display("FAIL timeout16 got stalls=%0d err=%0b rd=%h exp 17 1 00000000", stalls, berr, rd);
        end
        access(1'b0, F3_LW, 32'h504, 32'h0, 32'h0BAD_F00D, 0, 1'b1, rd, stalls, be, baddr, bwdata, bwe, stable, berr);
        checks++;
        if ({berr, rd} !== {1'b0, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL err_clears got err=%0b rd=%h exp 0 0badf00d", berr, rd);
        end
        cyc();
        to_read = 1'b1; Funct3M = F3_LW; ALU_ResultM = 32'h600; bus_gnt = 1'b1;
        settle();
        stalls = 0;
        for (int n = 0; n < 20; n++) begin
            if (!to_stall) break;
            stalls++;
            cyc(); settle();
        end
        checks++;
        if ({stalls, to_err, to_rdm, to_req} !== {32'd5, 1'b1, 32'h0, 1'b0}) begin
            errors++; $display("FAIL timeout4 got stalls=%0d err=%0b rd=%h req=%0b exp 5 1 00000000 0", stalls, to_err, to_rdm, to_req);
        end
        cyc(); idle_inputs(); settle();
    endtask

    task automatic test_reset_mid();
        cyc();
        MemReadM = 1'b1; Funct3M = F3_LW; ALU_ResultM = 32'h700; bus_gnt = 1'b1;
        settle();
        cyc(); settle();
        cyc(); settle();
        rst = 1'b0;
        #1;
        checks++;
        if ({ReadDataM, StallM, bus_addr, bus_be, bus_req} !== 70'h0) begin
            errors++; $display("FAIL reset_in_wait got rd=%h stall=%0b addr=%h be=%b req=%0b exp all 0", ReadDataM, StallM, bus_addr, bus_be, bus_req);
        end
        idle_inputs();
        cyc();
        rst = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        cyc(); cyc(); settle();
        checks++;
        if ({ReadDataM, StallM, bus_req} !== 34'h0) begin
            errors++; $display("FAIL stale_rvalid got rd=%h stall=%0b req=%0b exp 0 0 0", ReadDataM, StallM, bus_req);
        end
        bus_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_fault();
        test_gnt_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
